// File: rtl/de2_greenled_driver.sv
// de2_greenled_driver: LEDG pad driver adding PWM brightness and
// per-lane blinking to the green-LED PIO pattern.
//
// Ports:
//   clk, reset_n   system clock, async active-low reset
//   led_in         requested pattern from the PIO out_port
//   address        register select (0 CTRL, 1 BRIGHT, 2 MASK, 3 PERIOD)
//   chipselect     slave select
//   write_n        active-low write strobe
//   writedata      write data
//   readdata       combinational read data for address
//   led_out        registered drive to the LEDG pins
module de2_greenled_driver #(
    parameter int WIDTH        = 9,
    parameter int PRESCALE_DIV = 50000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] led_in,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] led_out
);

    localparam int PW =
        (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST =
        PW'(PRESCALE_DIV - 1);
    localparam logic [15:0] PERIOD_RST = 16'd500;

    logic             en;
    logic             inv;
    logic [7:0]       bright;
    logic [WIDTH-1:0] blink_mask;
    logic [15:0]      blink_period;

    logic [PW-1:0]    pre_cnt;
    logic             tick;
    logic [7:0]       pwm_cnt;
    logic             pwm_on;
    logic [15:0]      blk_cnt;
    logic             phase;
    logic [WIDTH-1:0] raw;

    logic wr;
    logic wr_ctrl;
    logic wr_bright;
    logic wr_mask;
    logic wr_period;

    // Upper write-data bits have no register behind them.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, writedata[31:16]};

    assign wr        = chipselect && !write_n;
    assign wr_ctrl   = wr && (address == 2'd0);
    assign wr_bright = wr && (address == 2'd1);
    assign wr_mask   = wr && (address == 2'd2);
    assign wr_period = wr && (address == 2'd3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en           <= 1'b1;
            inv          <= 1'b0;
            bright       <= 8'hFF;
            blink_mask   <= '0;
            blink_period <= PERIOD_RST;
        end else begin
            if (wr_ctrl) begin
                en  <= writedata[0];
                inv <= writedata[1];
            end
            if (wr_bright) begin
                bright <= writedata[7:0];
            end
            if (wr_mask) begin
                blink_mask <= writedata[WIDTH-1:0];
            end
            if (wr_period) begin
                blink_period <= writedata[15:0];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = {30'd0, inv, en};
            2'd1:    readdata = {24'd0, bright};
            2'd2:    readdata = 32'(blink_mask);
            default: readdata = {phase, 15'd0, blink_period};
        endcase
    end

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt <= 8'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end

    // 0xFF is treated as fully on rather than 255/256.
    always_comb begin
        pwm_on = (pwm_cnt < bright);
        if (bright == 8'hFF) begin
            pwm_on = 1'b1;
        end else if (bright == 8'h00) begin
            pwm_on = 1'b0;
        end
    end

    // A period write restarts the half-period with the lanes lit,
    // even when it lands on a terminal tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blk_cnt <= 16'd0;
            phase   <= 1'b1;
        end else if (wr_period) begin
            blk_cnt <= 16'd0;
            phase   <= 1'b1;
        end else if (blink_period == 16'd0) begin
            blk_cnt <= 16'd0;
            phase   <= 1'b1;
        end else if (tick) begin
            if (blk_cnt == blink_period - 16'd1) begin
                blk_cnt <= 16'd0;
                phase   <= ~phase;
            end else begin
                blk_cnt <= blk_cnt + 16'd1;
            end
        end
    end

    assign raw = led_in
               & {WIDTH{pwm_on}}
               & (~blink_mask | {WIDTH{phase}});

    // EN gates after the inverter so a disabled block stays dark.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out <= '0;
        end else if (!en) begin
            led_out <= '0;
        end else if (inv) begin
            led_out <= ~raw;
        end else begin
            led_out <= raw;
        end
    end

endmodule
